// File: rtl/rf_wr_arb.sv
// Two-requester register-file write arbiter with registered grant/write outputs.
// Define RF_ARB_RR_EN for round-robin arbitration; undefined gives fixed priority (requester 0 wins).
module rf_wr_arb (
  input  logic       clk,
  input  logic       clr,
  input  logic       req0,
  input  logic       req1,
  input  logic [2:0] wsel0,
  input  logic [2:0] wsel1,
  input  logic [7:0] d0,
  input  logic [7:0] d1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       rf_wen,
  output logic [2:0] rf_wsel,
  output logic [7:0] rf_d,
  output logic [7:0] vmask,
  output logic [7:0] wr_cnt
);

  logic       gnt0_q, gnt0_d;
  logic       gnt1_q, gnt1_d;
  logic       wen_q, wen_d;
  logic [2:0] wsel_q, wsel_d;
  logic [7:0] data_q, data_d;
  logic [7:0] vmask_q, vmask_d;
  logic [7:0] cnt_q, cnt_d;

`ifdef RF_ARB_RR_EN
  typedef enum logic {PRIO_R0 = 1'b0, PRIO_R1 = 1'b1} prio_e;
  prio_e prio_q, prio_d;
`endif

  always_comb begin
    gnt0_d = 1'b0;
    gnt1_d = 1'b0;
`ifdef RF_ARB_RR_EN
    prio_d = prio_q;
    if (req0 && (!req1 || prio_q == PRIO_R0)) begin
      gnt0_d = 1'b1;
    end else if (req1) begin
      gnt1_d = 1'b1;
    end
    // Pointer moves to the other requester after every grant.
    if (gnt0_d) begin
      prio_d = PRIO_R1;
    end else if (gnt1_d) begin
      prio_d = PRIO_R0;
    end
`else
    if (req0) begin
      gnt0_d = 1'b1;
    end else if (req1) begin
      gnt1_d = 1'b1;
    end
`endif
    wen_d  = gnt0_d | gnt1_d;
    wsel_d = wsel_q;
    data_d = data_q;
    if (gnt0_d) begin
      wsel_d = wsel0;
      data_d = d0;
    end else if (gnt1_d) begin
      wsel_d = wsel1;
      data_d = d1;
    end
    vmask_d = vmask_q;
    if (wen_d) begin
      vmask_d[wsel_d] = 1'b1;
    end
    cnt_d = wen_d ? cnt_q + 8'd1 : cnt_q;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      wen_q   <= 1'b0;
      wsel_q  <= '0;
      data_q  <= '0;
      vmask_q <= '0;
      cnt_q   <= '0;
`ifdef RF_ARB_RR_EN
      prio_q  <= PRIO_R0;
`endif
    end else begin
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      wen_q   <= wen_d;
      wsel_q  <= wsel_d;
      data_q  <= data_d;
      vmask_q <= vmask_d;
      cnt_q   <= cnt_d;
`ifdef RF_ARB_RR_EN
      prio_q  <= prio_d;
`endif
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign rf_wen  = wen_q;
  assign rf_wsel = wsel_q;
  assign rf_d    = data_q;
  assign vmask   = vmask_q;
  assign wr_cnt  = cnt_q;

endmodule

// File: tb/tb_rf_wr_arb.sv
// Self-checking bench for rf_wr_arb: directed scenarios plus randomized requesters
// checked against a per-edge reference model of the arbitration rules.
module tb_rf_wr_arb;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [2:0] wsel0 = '0, wsel1 = '0;
  logic [7:0] d0 = '0, d1 = '0;
  logic       gnt0, gnt1, rf_wen;
  logic [2:0] rf_wsel;
  logic [7:0] rf_d, vmask, wr_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_prio;       // requester favoured when both request
  logic [7:0] m_vmask;
  int         m_cnt;
  logic       e_gnt0, e_gnt1, e_wen;
  logic [2:0] e_wsel;
  logic [7:0] e_d;
  int         last_win;     // 0 none, 1 requester 0, 2 requester 1
  int         seq[$];

  rf_wr_arb dut (
    .clk(clk), .clr(clr),
    .req0(req0), .req1(req1),
    .wsel0(wsel0), .wsel1(wsel1),
    .d0(d0), .d1(d1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rf_wen(rf_wen), .rf_wsel(rf_wsel), .rf_d(rf_d),
    .vmask(vmask), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prio = 0; m_vmask = '0; m_cnt = 0;
    e_gnt0 = 1'b0; e_gnt1 = 1'b0; e_wen = 1'b0; e_wsel = '0; e_d = '0;
    last_win = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_gnt0"},  {31'd0, gnt0},   {31'd0, e_gnt0});
    check({tag, "_gnt1"},  {31'd0, gnt1},   {31'd0, e_gnt1});
    check({tag, "_wen"},   {31'd0, rf_wen}, {31'd0, e_wen});
    check({tag, "_wsel"},  {29'd0, rf_wsel}, {29'd0, e_wsel});
    check({tag, "_d"},     {24'd0, rf_d},   {24'd0, e_d});
    check({tag, "_vmask"}, {24'd0, vmask},  {24'd0, m_vmask});
    check({tag, "_cnt"},   {24'd0, wr_cnt}, m_cnt % 256);
    check({tag, "_excl"},  {31'd0, gnt0 & gnt1}, 32'd0);
  endtask

  // One clock edge: predict from the inputs presented, then compare after the edge.
  task automatic step(input string tag);
    int win;
    win = 0;
    if (req0 && req1) begin
`ifdef RF_ARB_RR_EN
      win = m_prio + 1;
`else
      win = 1;
`endif
    end else if (req0) win = 1;
    else if (req1) win = 2;
    e_gnt0 = (win == 1);
    e_gnt1 = (win == 2);
    e_wen  = (win != 0);
    if (win == 1) begin e_wsel = wsel0; e_d = d0; end
    if (win == 2) begin e_wsel = wsel1; e_d = d1; end
    if (win != 0) begin
      m_vmask[e_wsel] = 1'b1;
      m_cnt  = m_cnt + 1;
      m_prio = (win == 1) ? 1 : 0;
    end
    last_win = win;
    @(posedge clk); #1;
    check_all(tag);
  endtask

  // Called at posedge+1; reset is asserted between edges and released before the next one.
  task automatic do_reset(input string tag);
    #1 clr = 1'b1;
    #1;
    model_reset();
    check_all({tag, "_async"});
    @(posedge clk); #1;
    check_all({tag, "_hold"});
    #2 clr = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    check_all("por");
    @(posedge clk); #1;
    check_all("por_hold");
    #2 clr = 1'b0;

    // Single write from requester 0
    req0 = 1'b1; wsel0 = 3'd3; d0 = 8'hA5;
    step("r030");
    check("r030_vmask_const", {24'd0, vmask}, 32'h08);
    check("r030_cnt_const", {24'd0, wr_cnt}, 32'd1);
    req0 = 1'b0;
    step("idle");

    // Both held high for four edges after reset
    do_reset("rst1");
    req0 = 1'b1; wsel0 = 3'd1; d0 = 8'h10;
    req1 = 1'b1; wsel1 = 3'd2; d1 = 8'h20;
    seq.delete();
    for (int i = 0; i < 4; i++) begin
      step("both_held");
      seq.push_back(last_win);
    end
`ifdef RF_ARB_RR_EN
    check("r031_seq", {seq[0][7:0], seq[1][7:0], seq[2][7:0], seq[3][7:0]}, 32'h01020102);
`else
    check("r032_seq", {seq[0][7:0], seq[1][7:0], seq[2][7:0], seq[3][7:0]}, 32'h01010101);
`endif
    check("r031_cnt_const", {24'd0, wr_cnt}, 32'd4);

    // Same target register from both requesters
    do_reset("rst2");
    req0 = 1'b1; wsel0 = 3'd5; d0 = 8'h11;
    req1 = 1'b1; wsel1 = 3'd5; d1 = 8'h22;
    step("r033_a");
    check("r033_first", {24'd0, rf_d}, 32'h11);
    req0 = 1'b0;
    step("r033_b");
    check("r033_second", {24'd0, rf_d}, 32'h22);
    check("r033_vmask5", {31'd0, vmask[5]}, 32'd1);
    req1 = 1'b0;
    step("r033_idle");

    // Randomized requesters: holding until granted, then re-issuing or dropping
    for (int i = 0; i < 400; i++) begin
      if (last_win == 1 || !req0) begin
        req0 = ($urandom_range(0, 2) != 0);
        wsel0 = 3'($urandom_range(0, 7));
        d0 = 8'($urandom);
      end
      if (last_win == 2 || !req1) begin
        req1 = ($urandom_range(0, 2) != 0);
        wsel1 = 3'($urandom_range(0, 7));
        d1 = 8'($urandom);
      end
      step("rand");
    end
    req0 = 1'b0; req1 = 1'b0;

    // 256 back-to-back single writes wrap the write counter
    do_reset("rst3");
    req0 = 1'b1;
    for (int i = 0; i < 256; i++) begin
      wsel0 = 3'($urandom_range(0, 7));
      d0 = 8'($urandom);
      step("wrap");
    end
    req0 = 1'b0;
    check("r034_wrap_const", {24'd0, wr_cnt}, 32'd0);
    check("r034_vmask_full", {24'd0, vmask}, {24'd0, m_vmask});

    // Reset while a grant is visible, then confirm priority restarts at requester 0
    req1 = 1'b1; wsel1 = 3'd6; d1 = 8'h66;
    step("pre_midrst");
    check("pre_midrst_gnt1", {31'd0, gnt1}, 32'd1);
    #1 clr = 1'b1;
    #1;
    model_reset();
    check_all("midrst");
    #2 clr = 1'b0;
    req0 = 1'b1; wsel0 = 3'd7; d0 = 8'h77;
    step("postrst");
    check("postrst_gnt0", {31'd0, gnt0}, 32'd1);
    req0 = 1'b0;
    step("postrst_b");
    req1 = 1'b0;
    step("final_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
